// File: rtl/nibble_pkg.sv
// nibble_pkg
//   Shared types and defaults for the nibble serializer datapath.
//   NIBBLE_W_DEF / NIBBLES_DEF : default nibble width and nibbles per word.
//   ser_state_t                : serializer control state (IDLE, SHIFT).
//   nibble_t                   : one default-width nibble.
package nibble_pkg;

    localparam int NIBBLE_W_DEF = 4;
    localparam int NIBBLES_DEF  = 4;

    typedef enum logic {
        IDLE,
        SHIFT
    } ser_state_t;

    typedef logic [3:0] nibble_t;

endpackage

// File: rtl/nibble_shreg.sv
// nibble_shreg
//   Loadable right-shift register that presents its lowest nibble.
//   clk    : clock, posedge
//   rst_n  : asynchronous active-low reset, clears the register
//   load   : capture din (takes priority over shift)
//   shift  : shift right by one nibble, zero-filling from the top
//   din    : word to load
//   nib    : lowest nibble of the held word
module nibble_shreg
    import nibble_pkg::*;
#(
    parameter int NIBBLE_W = NIBBLE_W_DEF,
    parameter int NIBBLES  = NIBBLES_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic                         shift,
    input  logic [NIBBLE_W*NIBBLES-1:0]  din,
    output logic [NIBBLE_W-1:0]          nib
);

    localparam int WORD_W = NIBBLE_W * NIBBLES;

    logic [WORD_W-1:0] sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh <= '0;
        end else if (load) begin
            sh <= din;
        end else if (shift) begin
            sh <= sh >> NIBBLE_W;
        end
    end

    assign nib = sh[NIBBLE_W-1:0];

endmodule

// File: rtl/nibble_serializer.sv
// nibble_serializer
//   Accepts one word on a valid/ready input and emits it as NIBBLES nibbles,
//   least-significant first, on a valid/ready output.
//   clk       : clock, posedge
//   rst_n     : asynchronous active-low reset
//   in_data   : word to transmit
//   in_valid  : in_data valid
//   in_ready  : a word can be accepted this cycle (combinational from out_ready)
//   out_nib   : current nibble
//   out_valid : out_nib valid
//   out_ready : downstream accepts out_nib this cycle
//   out_last  : out_nib is the final nibble of its word
module nibble_serializer
    import nibble_pkg::*;
#(
    parameter int NIBBLE_W = NIBBLE_W_DEF,
    parameter int NIBBLES  = NIBBLES_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NIBBLE_W*NIBBLES-1:0]  in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [NIBBLE_W-1:0]          out_nib,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last
);

    localparam int               CNT_W    = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

    ser_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             is_last;
    logic             out_fire;
    logic             in_fire;

    assign is_last  = (cnt == CNT_LAST);
    assign out_last = out_valid & is_last;
    assign out_fire = out_valid & out_ready;

    // Ready also opens while the last nibble leaves, so a new word can load
    // on the same edge with no bubble. Gated by rst_n so nothing is offered
    // while reset is held.
    assign in_ready = rst_n & ((state == IDLE) | (out_fire & is_last));
    assign in_fire  = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else if (in_fire) begin
            // Covers both a load from IDLE and a load overlapping the last
            // nibble's departure.
            state     <= SHIFT;
            cnt       <= '0;
            out_valid <= 1'b1;
        end else if (out_fire) begin
            if (is_last) begin
                state     <= IDLE;
                out_valid <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    nibble_shreg #(
        .NIBBLE_W (NIBBLE_W),
        .NIBBLES  (NIBBLES)
    ) u_shreg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (in_fire),
        .shift (out_fire & ~is_last),
        .din   (in_data),
        .nib   (out_nib)
    );

endmodule

// File: tb/tb_nibble_serializer.sv
module tb_nibble_serializer;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  out_nib;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    int checks = 0;
    int errors = 0;

    // Reference model: the word currently being transmitted and which
    // nibble of it is on the output.
    bit          m_has;
    logic [15:0] m_word;
    int          m_idx;

    // Values observed in the most recent step, for literal checks.
    logic [3:0]  obs_nib;
    logic        obs_vld;
    logic        obs_last;
    logic        obs_rdy;

    nibble_serializer #(
        .NIBBLE_W (4),
        .NIBBLES  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_nib   (out_nib),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs just after the falling edge, compare the DUT
    // with the model, then advance the model across the rising edge.
    task automatic step(input logic iv, input logic [15:0] id, input logic ordy);
        logic       e_vld, e_last, e_rdy, m_in_fire, m_out_fire;
        logic [3:0] e_nib;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
        e_vld  = m_has;
        e_nib  = 4'((m_word >> (4 * m_idx)) & 16'hF);
        e_last = m_has && (m_idx == 3);
        e_rdy  = rst_n && (!m_has || (ordy && m_idx == 3));
        obs_nib  = out_nib;
        obs_vld  = out_valid;
        obs_last = out_last;
        obs_rdy  = in_ready;
        chk("out_valid", 16'(out_valid), 16'(e_vld));
        chk("out_last",  16'(out_last),  16'(e_last));
        chk("in_ready",  16'(in_ready),  16'(e_rdy));
        if (e_vld) chk("out_nib", 16'(out_nib), 16'(e_nib));
        m_in_fire  = iv && e_rdy;
        m_out_fire = e_vld && ordy;
        @(posedge clk);
        if (!rst_n) begin
            m_has = 1'b0;
            m_idx = 0;
        end else begin
            if (m_out_fire) begin
                if (m_idx == 3) m_has = 1'b0;
                else            m_idx++;
            end
            if (m_in_fire) begin
                m_has  = 1'b1;
                m_word = id;
                m_idx  = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] exp_nibs [8];
        logic       exp_rdy  [9];
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        m_has     = 1'b0;
        m_word    = '0;
        m_idx     = 0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_out_nib",   16'(out_nib),   16'd0);
        chk("rst_out_last",  16'(out_last),  16'd0);
        chk("rst_in_ready",  16'(in_ready),  16'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 16'(in_ready), 16'd1);
        @(negedge clk);

        // Single word
        exp_nibs[0] = 4'h3; exp_nibs[1] = 4'hC; exp_nibs[2] = 4'h5; exp_nibs[3] = 4'hA;
        step(1'b1, 16'hA5C3, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 16'h0000, 1'b1);
            chk("single_nib",  16'(obs_nib),  16'(exp_nibs[k]));
            chk("single_last", 16'(obs_last), 16'(k == 3));
        end
        step(1'b0, 16'h0000, 1'b1);
        chk("single_done_vld", 16'(obs_vld), 16'd0);
        chk("single_done_rdy", 16'(obs_rdy), 16'd1);

        // Back-to-back
        exp_nibs[0] = 4'h4; exp_nibs[1] = 4'h3; exp_nibs[2] = 4'h2; exp_nibs[3] = 4'h1;
        exp_nibs[4] = 4'hF; exp_nibs[5] = 4'hE; exp_nibs[6] = 4'hE; exp_nibs[7] = 4'hB;
        for (int k = 0; k < 9; k++) exp_rdy[k] = (k == 0 || k == 4 || k == 8);
        step(1'b1, 16'h1234, 1'b1);
        chk("b2b_rdy_idle", 16'(obs_rdy), 16'(exp_rdy[0]));
        for (int k = 0; k < 8; k++) begin
            step(k < 4, 16'hBEEF, 1'b1);
            chk("b2b_vld", 16'(obs_vld), 16'd1);
            chk("b2b_nib", 16'(obs_nib), 16'(exp_nibs[k]));
            chk("b2b_rdy", 16'(obs_rdy), 16'(exp_rdy[k + 1]));
        end
        step(1'b0, 16'h0000, 1'b1);
        chk("b2b_done_vld", 16'(obs_vld), 16'd0);

        // Backpressure: stall on the first nibble, then drain
        step(1'b1, 16'h0F0F, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 16'h0000, 1'b0);
            chk("bp_hold_nib", 16'(obs_nib), 16'hF);
            chk("bp_hold_vld", 16'(obs_vld), 16'd1);
            chk("bp_hold_rdy", 16'(obs_rdy), 16'd0);
        end
        exp_nibs[0] = 4'hF; exp_nibs[1] = 4'h0; exp_nibs[2] = 4'hF; exp_nibs[3] = 4'h0;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 16'h0000, 1'b1);
            chk("bp_nib",  16'(obs_nib),  16'(exp_nibs[k]));
            chk("bp_last", 16'(obs_last), 16'(k == 3));
        end

        // Ignored input while mid-word
        step(1'b1, 16'h1357, 1'b1);
        exp_nibs[0] = 4'h7; exp_nibs[1] = 4'h5; exp_nibs[2] = 4'h3; exp_nibs[3] = 4'h1;
        for (int k = 0; k < 4; k++) begin
            step(k < 3, 16'hFFFF, 1'b1);
            chk("ign_nib", 16'(obs_nib), 16'(exp_nibs[k]));
        end
        step(1'b0, 16'h0000, 1'b1);
        chk("ign_done_vld", 16'(obs_vld), 16'd0);

        // Reset mid-word
        step(1'b1, 16'h9876, 1'b1);
        step(1'b0, 16'h0000, 1'b1);
        chk("rmw_nib0", 16'(obs_nib), 16'h6);
        #2;
        chk("rmw_nib1", 16'(out_nib), 16'h7);
        rst_n = 1'b0;
        #1;
        chk("rmw_vld", 16'(out_valid), 16'd0);
        chk("rmw_nib", 16'(out_nib),   16'd0);
        chk("rmw_last", 16'(out_last), 16'd0);
        chk("rmw_rdy", 16'(in_ready),  16'd0);
        m_has = 1'b0;
        m_idx = 0;
        @(negedge clk);
        step(1'b1, 16'hFFFF, 1'b1);
        step(1'b1, 16'hFFFF, 1'b1);
        rst_n = 1'b1;
        step(1'b1, 16'h0001, 1'b1);
        chk("rmw_rel_rdy", 16'(obs_rdy), 16'd1);
        exp_nibs[0] = 4'h1; exp_nibs[1] = 4'h0; exp_nibs[2] = 4'h0; exp_nibs[3] = 4'h0;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 16'h0000, 1'b1);
            chk("rmw_new_vld", 16'(obs_vld), 16'd1);
            chk("rmw_new_nib", 16'(obs_nib), 16'(exp_nibs[k]));
        end

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 3) != 0), 16'($urandom()), ($urandom_range(0, 3) != 0));
        end
        // Random traffic with occasional async resets
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                rst_n = 1'b0;
                #1;
                chk("rand_rst_vld", 16'(out_valid), 16'd0);
                m_has = 1'b0;
                m_idx = 0;
                step(1'b1, 16'($urandom()), 1'b1);
                rst_n = 1'b1;
            end
            step(($urandom_range(0, 1) != 0), 16'($urandom()), ($urandom_range(0, 1) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
